// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Converts a 14-bit binary word to 4-digit BCD with a sequential
//   double-dabble engine (16 cycles per conversion) and time-multiplexes
//   the result onto a 4-digit common-anode seven-segment display.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   value      binary value to display (0..16383)
//   seg        segment cathodes, active-low, seg[0]=a .. seg[6]=g
//   dp         decimal point, active-low, always off
//   an         digit anodes, active-low, an[0]=ones .. an[3]=thousands
//   bcd        last converted BCD, [3:0]=ones .. [15:12]=thousands
//   ovf        last converted value exceeded 9999
//   conv_done  one-cycle pulse coinciding with a bcd/ovf update
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV   = 100000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] value,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic [15:0] bcd,
    output logic        ovf,
    output logic        conv_done
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // ------------------------------------------------------------------
    // Converter
    // ------------------------------------------------------------------
    state_t      state, state_nxt;
    logic [13:0] shreg, shreg_nxt;
    logic [15:0] acc, acc_nxt, acc_adj;
    logic [3:0]  iter, iter_nxt;
    logic        flag, flag_nxt;
    logic [15:0] bcd_nxt;
    logic        ovf_nxt;
    logic        done_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            acc       <= '0;
            iter      <= '0;
            flag      <= 1'b0;
            bcd       <= '0;
            ovf       <= 1'b0;
            conv_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            acc       <= acc_nxt;
            iter      <= iter_nxt;
            flag      <= flag_nxt;
            bcd       <= bcd_nxt;
            ovf       <= ovf_nxt;
            conv_done <= done_nxt;
        end
    end

    // Add-3 correction on every nibble that would overflow after doubling.
    always_comb begin
        acc_adj = acc;
        for (int unsigned k = 0; k < 4; k++) begin
            if (acc[4*k +: 4] >= 4'd5)
                acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        acc_nxt   = acc;
        iter_nxt  = iter;
        flag_nxt  = flag;
        bcd_nxt   = bcd;
        ovf_nxt   = ovf;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                shreg_nxt = value;
                acc_nxt   = '0;
                iter_nxt  = '0;
                flag_nxt  = (value > 14'd9999);
                state_nxt = SHIFT;
            end
            SHIFT: begin
                acc_nxt   = {acc_adj[14:0], shreg[13]};
                shreg_nxt = {shreg[12:0], 1'b0};
                if (iter == 4'd13)
                    state_nxt = DONE;
                else
                    iter_nxt = iter + 4'd1;
            end
            DONE: begin
                // Above 9999 the fifth digit is lost, so saturate instead.
                bcd_nxt   = flag ? 16'h9999 : acc;
                ovf_nxt   = flag;
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [CW-1:0] rcnt;
    logic [1:0]    idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rcnt <= '0;
            idx  <= '0;
        end else if (rcnt == CNT_MAX) begin
            rcnt <= '0;
            idx  <= idx + 2'd1;
        end else begin
            rcnt <= rcnt + CW'(1);
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [3:0] digit;
    logic       blank;
    logic [6:0] seg_nxt;

    // A digit is blanked when it and every more-significant digit are zero;
    // the ones digit always shows so that zero reads as "0".
    always_comb begin
        digit = bcd[{idx, 2'b00} +: 4];
        blank = 1'b0;
        case (idx)
            2'd1:    blank = (bcd[15:4]  == 12'd0);
            2'd2:    blank = (bcd[15:8]  == 8'd0);
            2'd3:    blank = (bcd[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
        if (ovf)
            seg_nxt = 7'b0111111;
        else if (BLANK_LEADING && blank)
            seg_nxt = 7'h7F;
        else
            seg_nxt = seg_decode(digit);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= seg_nxt;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver. Two instances (blanking on and
// off) share stimulus; a cycle-level reference model derived from the
// conversion/scan timing rules predicts every output after every edge.
module tb_seg7_scan_driver;

    localparam int unsigned RDIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] value;

    logic [6:0]  seg_b,  seg_nb;
    logic        dp_b,   dp_nb;
    logic [3:0]  an_b,   an_nb;
    logic [15:0] bcd_b,  bcd_nb;
    logic        ovf_b,  ovf_nb;
    logic        done_b, done_nb;

    always #5 clk = ~clk;

    seg7_scan_driver #(.REFRESH_DIV(RDIV), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .value(value),
        .seg(seg_b), .dp(dp_b), .an(an_b),
        .bcd(bcd_b), .ovf(ovf_b), .conv_done(done_b)
    );

    seg7_scan_driver #(.REFRESH_DIV(RDIV), .BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .value(value),
        .seg(seg_nb), .dp(dp_nb), .an(an_nb),
        .bcd(bcd_nb), .ovf(ovf_nb), .conv_done(done_nb)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          n = 0;      // edges since reset release
    int          cap = 0;    // value captured for the conversion in flight
    logic [15:0] m_bcd = '0;
    logic        m_ovf = 1'b0;
    logic [3:0]  e_an;
    logic [6:0]  e_seg_b, e_seg_nb;
    logic        e_done;

    function automatic logic [6:0] glyph(input int d);
        string      s;
        logic [6:0] g;
        case (d)
            0: s = "abcdef";
            1: s = "bc";
            2: s = "abdeg";
            3: s = "abcdg";
            4: s = "bcfg";
            5: s = "acdfg";
            6: s = "acdefg";
            7: s = "abc";
            8: s = "abcdefg";
            9: s = "abcdfg";
            default: s = "";
        endcase
        g = 7'h7F;
        for (int i = 0; i < s.len(); i++) begin
            int p;
            p = int'(s[i]) - 97;
            g[p] = 1'b0;
        end
        return g;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        int r;
        if (v > 9999) return 16'h9999;
        r = ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
        return 16'(r);
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] b, input logic o, input int k, input bit blank_on);
        logic [15:0] upper;
        int          d;
        upper = b >> (4 * k);
        d = int'(upper[3:0]);
        if (o) return 7'b0111111;
        if (blank_on && k > 0 && upper == 16'd0) return 7'h7F;
        return glyph(d);
    endfunction

    task automatic tick();
        int          old_idx;
        logic [15:0] ob;
        logic        oo;
        logic [3:0]  onehot;
        @(posedge clk);
        if (!rst_n) begin
            n = 0; m_bcd = '0; m_ovf = 1'b0;
            e_an = 4'hF; e_seg_b = 7'h7F; e_seg_nb = 7'h7F; e_done = 1'b0;
        end else begin
            old_idx = (n / RDIV) % 4;
            ob = m_bcd;
            oo = m_ovf;
            n++;
            onehot   = 4'b0001 << old_idx;
            e_an     = ~onehot;
            e_seg_b  = exp_seg(ob, oo, old_idx, 1'b1);
            e_seg_nb = exp_seg(ob, oo, old_idx, 1'b0);
            e_done   = 1'b0;
            if (n % 16 == 1) cap = int'(value);
            if (n % 16 == 0) begin
                m_bcd  = to_bcd(cap);
                m_ovf  = (cap > 9999);
                e_done = 1'b1;
            end
        end
        #1;
        check("bcd",     32'(bcd_b),   32'(m_bcd));
        check("ovf",     32'(ovf_b),   32'(m_ovf));
        check("done",    32'(done_b),  32'(e_done));
        check("an",      32'(an_b),    32'(e_an));
        check("seg",     32'(seg_b),   32'(e_seg_b));
        check("dp",      32'(dp_b),    32'(1'b1));
        check("bcd_nb",  32'(bcd_nb),  32'(m_bcd));
        check("done_nb", 32'(done_nb), 32'(e_done));
        check("an_nb",   32'(an_nb),   32'(e_an));
        check("seg_nb",  32'(seg_nb),  32'(e_seg_nb));
        check("dp_nb",   32'(dp_nb),   32'(1'b1));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    // Advance until the next edge is a capture edge.
    task automatic align();
        for (int i = 0; i < 16 && (n % 16) != 0; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        value = 14'd1234;
        run(3);
        rst_n = 1'b1;
        run(16);
        check("first_bcd", 32'(bcd_b), 32'(16'h1234));
        run(16);

        value = 14'd9999;  run(48);
        check("b9999", 32'(bcd_b), 32'(16'h9999));
        value = 14'd10000; run(48);
        check("ovf10000", 32'(ovf_b), 32'(1'b1));
        value = 14'd16383; run(48);

        value = 14'd7; run(48);
        value = 14'd0; run(48);

        align();
        value = 14'd42;
        tick();
        value = 14'd9000;
        run(15);
        check("mid_bcd", 32'(bcd_b), 32'(16'h0042));
        run(16);
        check("next_bcd", 32'(bcd_b), 32'(16'h9000));

        align();
        value = 14'd5678;
        tick();
        run(7);
        rst_n = 1'b0;
        tick();
        check("abort_bcd", 32'(bcd_b), 32'(16'h0000));
        rst_n = 1'b1;
        run(20);

        for (int i = 0; i < 200 * 16; i++) begin
            value = 14'($urandom_range(0, 16383));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
